// File: rtl/seq_divider_if.sv
// Start/done handshake and result bundle shared by the divider and its requester.
// The master issues operands and start; the slave returns busy/done, results and flags.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider producing one quotient bit per clock.
// Signed mode divides magnitudes, then applies signs so the result truncates toward zero.
module seq_divider #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             neg_n_q, neg_n_d;
    logic             neg_d_q, neg_d_d;
    logic             pend_dz_q, pend_dz_d;
    logic             pend_ovf_q, pend_ovf_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   trial;

    // MIN maps to 100..0, which is already its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        if (SIGNED && v[WIDTH-1]) return -v;
        return v;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        dvd_d       = dvd_q;
        neg_n_d     = neg_n_q;
        neg_d_d     = neg_d_q;
        pend_dz_d   = pend_dz_q;
        pend_ovf_d  = pend_ovf_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;
        // The extra top bit of the trial difference is the borrow, i.e. its sign.
        trial       = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dvd_d      = bus.dividend;
                    quo_d      = mag(bus.dividend);
                    dvs_d      = mag(bus.divisor);
                    rem_d      = '0;
                    cnt_d      = '0;
                    neg_n_d    = SIGNED && bus.dividend[WIDTH-1];
                    neg_d_d    = SIGNED && bus.divisor[WIDTH-1];
                    pend_dz_d  = (bus.divisor == '0);
                    pend_ovf_d = SIGNED && (bus.dividend == MIN_VAL) && (bus.divisor == '1);
                    state_d    = (bus.divisor == '0) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (!trial[WIDTH]) rem_d = trial[WIDTH-1:0];
                else               rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = S_FIX;
            end
            S_FIX: begin
                if (pend_dz_q) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                end else begin
                    quotient_d  = (neg_n_q ^ neg_d_q) ? -quo_q : quo_q;
                    remainder_d = neg_n_q ? -rem_q : rem_q;
                end
                div_zero_d = pend_dz_q;
                overflow_d = pend_ovf_q;
                done_d     = 1'b1;
                state_d    = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            dvd_q       <= '0;
            neg_n_q     <= 1'b0;
            neg_d_q     <= 1'b0;
            pend_dz_q   <= 1'b0;
            pend_ovf_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            dvd_q       <= dvd_d;
            neg_n_q     <= neg_n_d;
            neg_d_q     <= neg_d_d;
            pend_dz_q   <= pend_dz_d;
            pend_ovf_q  <= pend_ovf_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: a signed and an unsigned 8-bit instance checked against
// an integer-arithmetic reference model, directed corner cases and a random sweep.
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   sel = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(8)) bs ();
    seq_divider_if #(.WIDTH(8)) bu ();

    seq_divider #(.WIDTH(8), .SIGNED(1'b1)) u_sdiv (.clk(clk), .rst_n(rst_n), .bus(bs));
    seq_divider #(.WIDTH(8), .SIGNED(1'b0)) u_udiv (.clk(clk), .rst_n(rst_n), .bus(bu));

    logic       done_m, busy_m, dz_m, ov_m;
    logic [7:0] q_m, r_m;
    assign done_m = sel ? bs.done      : bu.done;
    assign busy_m = sel ? bs.busy      : bu.busy;
    assign dz_m   = sel ? bs.div_zero  : bu.div_zero;
    assign ov_m   = sel ? bs.overflow  : bu.overflow;
    assign q_m    = sel ? bs.quotient  : bu.quotient;
    assign r_m    = sel ? bs.remainder : bu.remainder;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sgn, input logic st, input logic [7:0] n, input logic [7:0] d);
        if (sgn) begin
            bs.start = st; bs.dividend = n; bs.divisor = d;
        end else begin
            bu.start = st; bu.dividend = n; bu.divisor = d;
        end
    endtask

    // Reference: plain integer division (truncates toward zero) plus the two special cases.
    function automatic void model(input bit sgn, input logic [7:0] n, input logic [7:0] d,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dz, output logic ov);
        int ni, di;
        ni = sgn ? int'($signed(n)) : int'(n);
        di = sgn ? int'($signed(d)) : int'(d);
        dz = 1'b0; ov = 1'b0;
        if (di == 0) begin
            q = 8'hFF; r = n; dz = 1'b1;
        end else if (sgn && ni == -128 && di == -1) begin
            q = 8'h80; r = 8'h00; ov = 1'b1;
        end else begin
            q = 8'(ni / di);
            r = 8'(ni % di);
        end
    endfunction

    // Runs one operation; poke >= 0 pulses start with other operands that many edges after E0.
    task automatic do_case(input string tag, input bit sgn, input logic [7:0] n,
                           input logic [7:0] d, input int poke);
        logic [7:0] eq, er;
        logic       edz, eov;
        int         edges, busy_cyc;
        model(sgn, n, d, eq, er, edz, eov);
        sel = sgn;
        @(negedge clk);
        drive(sgn, 1'b1, n, d);
        @(posedge clk);
        #1 drive(sgn, 1'b0, 8'($urandom), 8'($urandom));
        edges = 0; busy_cyc = 0;
        while (edges < 40) begin
            @(negedge clk);
            if (busy_m) busy_cyc++;
            if (done_m) break;
            if (edges == poke) drive(sgn, 1'b1, 8'($urandom), 8'($urandom_range(1, 255)));
            @(posedge clk);
            #1 drive(sgn, 1'b0, 8'($urandom), 8'($urandom));
            edges++;
        end
        chk({tag, " latency"}, edges + 1, edz ? 2 : 10);
        chk({tag, " busy_cycles"}, busy_cyc, edz ? 1 : 9);
        chk({tag, " quotient"}, q_m, eq);
        chk({tag, " remainder"}, r_m, er);
        chk({tag, " div_zero"}, dz_m, edz);
        chk({tag, " overflow"}, ov_m, eov);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, done_m, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ni, di, qi, ri, saw_done;
        bit sgn;
        logic [7:0] n, d;
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("reset quotient", bs.quotient, 8'h00);
        chk("reset remainder", bs.remainder, 8'h00);
        chk("reset flags", {bs.busy, bs.done, bs.div_zero, bs.overflow}, 4'h0);
        @(negedge clk) rst_n = 1'b1;

        do_case("s 100/7",      1'b1, 8'd100, 8'd7,   -1);
        do_case("s -100/7",     1'b1, 8'h9C,  8'd7,   -1);
        do_case("s 100/-7",     1'b1, 8'd100, 8'hF9,  -1);
        do_case("s 2A/0",       1'b1, 8'h2A,  8'h00,  -1);
        do_case("s -128/-1",    1'b1, 8'h80,  8'hFF,  -1);
        do_case("s 100/7 poke", 1'b1, 8'd100, 8'd7,    3);
        do_case("s -128/1",     1'b1, 8'h80,  8'h01,  -1);

        // Abort mid-RUN: outputs clear immediately and no done follows.
        sel = 1'b1;
        @(negedge clk) drive(1'b1, 1'b1, 8'd100, 8'd7);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 8'h00, 8'h00);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort quotient", bs.quotient, 8'h00);
        chk("abort remainder", bs.remainder, 8'h00);
        chk("abort flags", {bs.busy, bs.done, bs.div_zero, bs.overflow}, 4'h0);
        saw_done = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (bs.done || bs.busy) saw_done++;
        end
        chk("abort no_done", saw_done, 0);
        do_case("s after abort", 1'b1, 8'hE7, 8'd5, -1);

        do_case("u 255/16", 1'b0, 8'd255, 8'd16, -1);
        do_case("u 200/0",  1'b0, 8'd200, 8'h00, -1);
        do_case("u 128/255", 1'b0, 8'h80, 8'hFF, -1);

        for (int i = 0; i < 60; i++) begin
            sgn = 1'($urandom);
            n = 8'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 9) == 0) d = 8'h00;
            if ($urandom_range(0, 14) == 0) begin n = 8'h80; d = 8'hFF; end
            do_case("rand", sgn, n, d, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1);
            if (d != 8'h00 && !(sgn && n == 8'h80 && d == 8'hFF)) begin
                ni = sgn ? int'($signed(n)) : int'(n);
                di = sgn ? int'($signed(d)) : int'(d);
                qi = sgn ? int'($signed(q_m)) : int'(q_m);
                ri = sgn ? int'($signed(r_m)) : int'(r_m);
                chk("rand identity", qi * di + ri, ni);
                chk("rand rem_mag", ((ri < 0 ? -ri : ri) < (di < 0 ? -di : di)) ? 1 : 0, 1);
                chk("rand rem_sign", (ri == 0 || ((ri < 0) == (ni < 0))) ? 1 : 0, 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
